// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 UART receiver with 16x oversampling and a 3-sample majority vote.
// Bytes are delivered through a one-entry holding register with a valid/ready handshake.
module uart_rx #(
    parameter int TICK_DIV   = 54,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_sync1;
    logic        r_sync2;
    logic [TW-1:0] r_tickCnt;
    logic [3:0]  r_bcnt;
    logic [2:0]  r_bitIdx;
    logic [7:0]  r_shift;
    logic        r_s7;
    logic        r_s8;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_overrun;
    logic        r_frameErr;

    logic        w_rxs;
    logic        w_tick;
    logic        w_decide;
    logic        w_bitEnd;
    logic        w_maj;
    logic        w_goodStop;
    logic        w_badStop;
    logic        w_xfer;

    assign w_rxs      = r_sync2;
    assign w_tick     = (r_tickCnt == TW'(TICK_DIV - 1));
    assign w_decide   = w_tick && (r_bcnt == 4'd9);
    assign w_bitEnd   = w_tick && (r_bcnt == 4'(OVERSAMPLE - 1));
    assign w_maj      = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
    assign w_goodStop = (r_state == STOP) && w_decide && w_maj;
    assign w_badStop  = (r_state == STOP) && w_decide && !w_maj;
    assign w_xfer     = r_valid && rx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_tickCnt <= '0;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_tickCnt <= w_tick ? '0 : r_tickCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The good-stop decision returns to IDLE mid stop bit so back-to-back frames resync.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_tick && !w_rxs) w_nextState = START;
            START: begin
                if (w_decide && w_maj) w_nextState = IDLE;
                else if (w_bitEnd)     w_nextState = DATA;
            end
            DATA:    if (w_bitEnd && (r_bitIdx == 3'd7)) w_nextState = STOP;
            STOP:    if (w_decide) w_nextState = w_maj ? IDLE : BREAK;
            BREAK:   if (w_tick && w_rxs) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The IDLE detection tick counts as bcnt 0, so START continues from 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcnt   <= 4'd0;
            r_bitIdx <= 3'd0;
            r_shift  <= 8'h00;
            r_s7     <= 1'b1;
            r_s8     <= 1'b1;
        end else if (w_tick) begin
            if (r_state == IDLE) begin
                r_bcnt   <= 4'd1;
                r_bitIdx <= 3'd0;
            end else begin
                r_bcnt <= r_bcnt + 4'd1;
            end
            if (r_bcnt == 4'd7) r_s7 <= w_rxs;
            if (r_bcnt == 4'd8) r_s8 <= w_rxs;
            if ((r_state == DATA) && (r_bcnt == 4'd9)) r_shift <= {w_maj, r_shift[7:1]};
            if ((r_state == DATA) && w_bitEnd) r_bitIdx <= r_bitIdx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_frameErr <= w_badStop;
            if (w_goodStop && (!r_valid || rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            // A byte completing into a full, unconsumed register is dropped.
            if (w_xfer) begin
                r_overrun <= 1'b0;
            end else if (w_goodStop && r_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        rx_data   = r_data;
        rx_valid  = r_valid;
        overrun   = r_overrun;
        frame_err = r_frameErr;
        busy      = (r_state != IDLE);
    end
endmodule
